// File: rtl/sum_seg_display_pkg.sv
// ----------------------------------------------------------------------------
// sum_disp_pkg
// Shared constants and types for the sum-to-7-segment display path:
//   - SUM_W / BCD_W : binary sum width and packed 3-digit BCD width
//   - SEG_0..SEG_9  : active-low segment patterns {g,f,e,d,c,b,a}
//   - SEG_BLANK     : all segments off
//   - conv_state_t  : states of the sequential binary-to-BCD converter
//   - seg_decode()  : BCD nibble to segment pattern (non-decimal -> blank)
// ----------------------------------------------------------------------------
package sum_disp_pkg;

    localparam int SUM_W = 8;
    localparam int BCD_W = 12;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
        logic [6:0] v_seg;
        case (i_digit)
            4'd0:    v_seg = SEG_0;
            4'd1:    v_seg = SEG_1;
            4'd2:    v_seg = SEG_2;
            4'd3:    v_seg = SEG_3;
            4'd4:    v_seg = SEG_4;
            4'd5:    v_seg = SEG_5;
            4'd6:    v_seg = SEG_6;
            4'd7:    v_seg = SEG_7;
            4'd8:    v_seg = SEG_8;
            4'd9:    v_seg = SEG_9;
            default: v_seg = SEG_BLANK;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/sum_seg_display_if.sv
// ----------------------------------------------------------------------------
// sum_seg_display_if
// Load/result bus between the adder side (master) and the display block
// (slave).
//   sum_i        master->slave  8-bit binary sum, sampled on accepted load
//   load_i       master->slave  load strobe
//   busy_o       slave->master  conversion in progress
//   bcd_o        slave->master  {hundreds,tens,ones} of last conversion
//   bcd_valid_o  slave->master  one-cycle pulse when bcd_o updates
// ----------------------------------------------------------------------------
interface sum_seg_display_if;
    import sum_disp_pkg::*;

    logic [SUM_W-1:0] sum_i;
    logic             load_i;
    logic             busy_o;
    logic [BCD_W-1:0] bcd_o;
    logic             bcd_valid_o;

    modport master (
        output sum_i,
        output load_i,
        input  busy_o,
        input  bcd_o,
        input  bcd_valid_o
    );

    modport slave (
        input  sum_i,
        input  load_i,
        output busy_o,
        output bcd_o,
        output bcd_valid_o
    );

endinterface

// File: rtl/sum_seg_display_bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 8-bit binary -> 3-digit packed BCD.
// A load accepted at edge N produces the result and a one-cycle valid pulse
// at edge N+9; busy is high in between and loads are ignored while busy.
// Ports:
//   clk_i        in   system clock
//   rst_i        in   synchronous active-high reset (aborts a conversion)
//   i_sum        in   binary value to convert
//   i_load       in   load strobe, honoured only when idle
//   o_busy       out  conversion in progress
//   o_bcd        out  last completed result, stable during conversion
//   o_bcd_valid  out  one-cycle pulse when o_bcd updates
// ----------------------------------------------------------------------------
module bin2bcd_seq
    import sum_disp_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SUM_W-1:0] i_sum,
    input  logic             i_load,
    output logic             o_busy,
    output logic [BCD_W-1:0] o_bcd,
    output logic             o_bcd_valid
);

    conv_state_t      r_state;
    logic [SUM_W-1:0] r_shreg;
    logic [BCD_W-1:0] r_scratch;
    logic [2:0]       r_cnt;
    logic             r_busy;
    logic [BCD_W-1:0] r_bcd;
    logic             r_valid;
    logic [BCD_W-1:0] w_adj;

    function automatic logic [3:0] add3(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
    endfunction

    // Digit correction is applied before the shift so that each nibble
    // doubles into a valid BCD digit plus carry.
    always_comb begin
        w_adj = {add3(r_scratch[11:8]), add3(r_scratch[7:4]), add3(r_scratch[3:0])};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_bcd     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_shreg   <= i_sum;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // o_bcd only changes here, so the display never sees a
                    // partially shifted value.
                    r_bcd   <= r_scratch;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = r_busy;
    assign o_bcd       = r_bcd;
    assign o_bcd_valid = r_valid;

endmodule

// File: rtl/sum_seg_display.sv
// ----------------------------------------------------------------------------
// sum_seg_display
// Converts the adder's 8-bit sum to decimal and shows it on a 4-digit,
// active-low, multiplexed 7-segment display (digit 3 is unused and dark).
// Parameters:
//   REFRESH_DIV  clock cycles per digit slot (>= 2)
//   BLANK_LZ     1 = blank leading zeros in hundreds/tens
// Ports:
//   clk_i   in   system clock
//   rst_i   in   synchronous active-high reset
//   bus     slave modport: sum_i, load_i, busy_o, bcd_o, bcd_valid_o
//   an_o    out  digit anodes, active-low, an_o[0] = ones
//   seg_o   out  segments {g,f,e,d,c,b,a}, active-low
//   dp_o    out  decimal point, always off
// ----------------------------------------------------------------------------
module sum_seg_display
    import sum_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    sum_seg_display_if.slave         bus,
    output logic [3:0]               an_o,
    output logic [6:0]               seg_o,
    output logic                     dp_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic             w_busy;
    logic [BCD_W-1:0] w_bcd;
    logic             w_bcd_valid;

    logic [CNT_W-1:0] r_refresh;
    logic [1:0]       r_slot;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;

    logic             w_wrap;
    logic [1:0]       w_slot_nxt;
    logic [3:0]       w_an_nxt;
    logic [6:0]       w_seg_nxt;
    logic [3:0]       w_hund;
    logic [3:0]       w_tens;
    logic [3:0]       w_ones;

    bin2bcd_seq u_bin2bcd (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_sum       (bus.sum_i),
        .i_load      (bus.load_i),
        .o_busy      (w_busy),
        .o_bcd       (w_bcd),
        .o_bcd_valid (w_bcd_valid)
    );

    assign bus.busy_o      = w_busy;
    assign bus.bcd_o       = w_bcd;
    assign bus.bcd_valid_o = w_bcd_valid;

    assign w_hund = w_bcd[11:8];
    assign w_tens = w_bcd[7:4];
    assign w_ones = w_bcd[3:0];

    assign w_wrap     = (r_refresh == CNT_W'(REFRESH_DIV - 1));
    assign w_slot_nxt = w_wrap ? r_slot + 2'd1 : r_slot;

    // Digit drive is computed from the slot value being loaded this edge, so
    // an_o/seg_o switch on exactly the same edge as the slot register.
    always_comb begin
        w_an_nxt  = 4'b1111;
        w_seg_nxt = SEG_BLANK;
        case (w_slot_nxt)
            2'd0: begin
                w_an_nxt  = 4'b1110;
                w_seg_nxt = seg_decode(w_ones);
            end
            2'd1: begin
                w_an_nxt  = 4'b1101;
                w_seg_nxt = (BLANK_LZ && w_hund == 4'd0 && w_tens == 4'd0)
                            ? SEG_BLANK : seg_decode(w_tens);
            end
            2'd2: begin
                w_an_nxt  = 4'b1011;
                w_seg_nxt = (BLANK_LZ && w_hund == 4'd0)
                            ? SEG_BLANK : seg_decode(w_hund);
            end
            default: begin
                w_an_nxt  = 4'b1111;
                w_seg_nxt = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_refresh <= '0;
            r_slot    <= 2'd0;
            r_an      <= 4'b1111;
            r_seg     <= SEG_BLANK;
        end else begin
            r_refresh <= w_wrap ? '0 : r_refresh + CNT_W'(1);
            r_slot    <= w_slot_nxt;
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;
    assign dp_o  = 1'b1;

endmodule

// File: tb/tb_sum_seg_display.sv
// ----------------------------------------------------------------------------
// tb_sum_seg_display
// Randomised self-checking bench for sum_seg_display with REFRESH_DIV=4.
// Expected decimal digits and segment patterns come from plain arithmetic on
// the loaded value and a digit-to-segment table.
// ----------------------------------------------------------------------------
module tb_sum_seg_display;

    logic       clk;
    logic       rst;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total;
    int bad;

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    sum_seg_display_if bus ();

    sum_seg_display #(
        .REFRESH_DIV (4),
        .BLANK_LZ    (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus),
        .an_o  (an),
        .seg_o (seg),
        .dp_o  (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    function automatic logic [3:0] exp_an(input int s);
        case (s)
            0:       return 4'b1110;
            1:       return 4'b1101;
            2:       return 4'b1011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int s);
        int d;
        if (s == 0)      d = v % 10;
        else if (s == 1) d = (v / 10) % 10;
        else             d = v / 100;
        if (s == 2 && v < 100) return 7'h7F;
        if (s == 1 && v < 10)  return 7'h7F;
        return segtab[d];
    endfunction

    // Caller must be at a negedge. Drives a load for the next edge (N) and
    // checks the busy window, result and valid pulse through edge N+9.
    // Returns at the negedge after edge N+9.
    task automatic conv_check(input int v, input string tag);
        logic [11:0] exp_bcd;
        logic [11:0] old_bcd;
        int win_bad;
        exp_bcd = to_bcd(v);
        old_bcd = bus.bcd_o;
        win_bad = 0;
        bus.sum_i  = 8'(v);
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        for (int k = 0; k < 9; k++) begin
            if (bus.busy_o !== 1'b1 || bus.bcd_valid_o !== 1'b0 || bus.bcd_o !== old_bcd)
                win_bad++;
            @(negedge clk);
        end
        total++;
        if (win_bad !== 0) begin
            bad++;
            $display("FAIL %s busy_window: bad cycles=%0d required 0", tag, win_bad);
        end
        total++;
        if (bus.bcd_o !== exp_bcd || bus.bcd_valid_o !== 1'b1 || bus.busy_o !== 1'b0) begin
            bad++;
            $display("FAIL %s result: bcd=%h valid=%b busy=%b required bcd=%h valid=1 busy=0",
                     tag, bus.bcd_o, bus.bcd_valid_o, bus.busy_o, exp_bcd);
        end
    endtask

    // Syncs to the first cycle of slot 0, then checks a full 16-cycle scan.
    task automatic scan_check(input int v, input string tag);
        int n;
        int slot_bad;
        n = 0;
        while (an === 4'b1110 && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (an !== 4'b1110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (an !== 4'b1110) begin
            bad++;
            $display("FAIL %s scan_sync: an=%b required 1110 within 40 cycles", tag, an);
            return;
        end
        for (int s = 0; s < 4; s++) begin
            slot_bad = 0;
            for (int c = 0; c < 4; c++) begin
                if (an !== exp_an(s) || dp !== 1'b1 || (s < 3 && seg !== exp_seg(v, s)))
                    slot_bad++;
                if (slot_bad == 1 && c >= 0 && (an !== exp_an(s) || (s < 3 && seg !== exp_seg(v, s))))
                    $display("  %s slot%0d cycle%0d an=%b seg=%b", tag, s, c, an, seg);
                @(negedge clk);
            end
            total++;
            if (slot_bad !== 0) begin
                bad++;
                $display("FAIL %s scan_slot%0d: bad cycles=%0d required an=%b seg=%b",
                         tag, s, slot_bad, exp_an(s), (s < 3) ? exp_seg(v, s) : 7'h7F);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.load_i = 1'b0;
        bus.sum_i  = 8'd0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b0 || bus.bcd_o !== 12'h000 || bus.bcd_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_conv: busy=%b bcd=%h valid=%b required 0 000 0",
                     bus.busy_o, bus.bcd_o, bus.bcd_valid_o);
        end
        total++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
            bad++;
            $display("FAIL reset_disp: an=%b seg=%h dp=%b required 1111 7f 1", an, seg, dp);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_slot0: an=%b seg=%b required 1110 1000000", an, seg);
        end
    endtask

    task automatic test_basic();
        conv_check(15, "basic15");
        @(negedge clk);
        total++;
        if (bus.bcd_valid_o !== 1'b0 || bus.bcd_o !== 12'h015) begin
            bad++;
            $display("FAIL basic15_pulse_width: valid=%b bcd=%h required 0 015",
                     bus.bcd_valid_o, bus.bcd_o);
        end
    endtask

    task automatic test_extremes();
        conv_check(255, "max255");
        @(negedge clk);
        scan_check(255, "max255");
        conv_check(0, "zero");
        @(negedge clk);
        scan_check(0, "zero");
    endtask

    task automatic test_drop();
        int pulses;
        logic [11:0] seen;
        pulses = 0;
        seen   = 12'hFFF;
        bus.sum_i  = 8'd42;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.sum_i  = 8'd99;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.bcd_valid_o === 1'b1) begin
                pulses++;
                seen = bus.bcd_o;
            end
            @(negedge clk);
        end
        total++;
        if (pulses !== 1 || seen !== 12'h042 || bus.bcd_o !== 12'h042) begin
            bad++;
            $display("FAIL drop_busy_load: pulses=%0d bcd=%h required 1 042", pulses, seen);
        end
    endtask

    task automatic test_back_to_back();
        int v;
        for (int i = 0; i < 4; i++) begin
            v = $urandom_range(255);
            conv_check(v, "b2b");
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int v;
        for (int i = 0; i < 6; i++) begin
            v = $urandom_range(255);
            conv_check(v, "rand");
            @(negedge clk);
            scan_check(v, "rand");
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        pulses = 0;
        bus.sum_i  = 8'd200;
        bus.load_i = 1'b1;
        @(negedge clk);
        bus.load_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (bus.busy_o !== 1'b0 || bus.bcd_o !== 12'h000 || bus.bcd_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b bcd=%h valid=%b required 0 000 0",
                     bus.busy_o, bus.bcd_o, bus.bcd_valid_o);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.bcd_valid_o === 1'b1 || bus.busy_o === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.bcd_o !== 12'h000) begin
            bad++;
            $display("FAIL reset_mid_abort: activity cycles=%0d bcd=%h required 0 000",
                     pulses, bus.bcd_o);
        end
    endtask

    task automatic test_scan_blank();
        int vals [5] = '{105, 9, 10, 99, 100};
        for (int i = 0; i < 5; i++) begin
            conv_check(vals[i], "blank");
            @(negedge clk);
            scan_check(vals[i], "blank");
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.load_i = 1'b0;
        bus.sum_i  = 8'd0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_extremes();
        test_drop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_scan_blank();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
